// File: rtl/sao_lcu_feeder.sv
// sao_lcu_feeder
//   Streams a 128x128 8-bit frame from the frame ROM into the SAO filter,
//   one LCU at a time, LCUs in raster order and pixels in raster order
//   inside each LCU. Per-LCU SAO parameters are fetched from the parameter
//   ROM and carried alongside every pixel through a 2-entry output FIFO.
//   The filter's busy signal stalls the head combinationally.
//
//   Optional feature: define SAO_FEED_STATS_EN to add stall_cnt/lcu_cnt.
module sao_lcu_feeder #(
  parameter int IMG_W    = 128,
  parameter int PARAM_AW = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          cfg_lcu_size,
  output logic [13:0]         fm_addr,
  output logic                fm_rd,
  input  logic [7:0]          fm_q,
  output logic [PARAM_AW-1:0] pm_addr,
  output logic                pm_rd,
  input  logic [23:0]         pm_q,
  output logic                in_en,
  output logic [7:0]          din,
  output logic [1:0]          sao_type,
  output logic [4:0]          sao_band_pos,
  output logic                sao_eo_class,
  output logic [15:0]         sao_offset,
  output logic [2:0]          lcu_x,
  output logic [2:0]          lcu_y,
  output logic [1:0]          lcu_size,
  input  logic                busy,
  output logic                done
`ifdef SAO_FEED_STATS_EN
  ,
  output logic [15:0]         stall_cnt,
  output logic [6:0]          lcu_cnt
`endif
);

  localparam int PIX_W = $clog2(IMG_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PARAM,
    S_PWAIT,
    S_STREAM,
    S_NEXT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t      state;
  logic [1:0]  size_q;
  logic [2:0]  cur_x;
  logic [2:0]  cur_y;
  logic [5:0]  row;
  logic [5:0]  col;
  logic [23:0] param_q;

  // Read issued last cycle whose data is on fm_q now.
  logic        inflight;

  // Output FIFO: {pixel, params, lcu_x, lcu_y}.
  logic [37:0] mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  fifo_count;

  logic [5:0]       n_m1;
  logic [2:0]       lpr_m1;
  logic [2:0]       lcu_sh;
  logic [PIX_W-1:0] x_base;
  logic [PIX_W-1:0] y_base;
  logic [5:0]       pm_idx;
  logic [2:0]       credit_used;
  logic [2:0]       credit_lim;
  logic             start_ok;

  // LCU geometry and ROM addressing derived from the current position.
  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    n_m1        = 6'((16 << size_q) - 1);
    lpr_m1      = 3'((IMG_W / 16 - 1) >> size_q);
    lcu_sh      = 3'd4 + {1'b0, size_q};
    x_base      = PIX_W'(cur_x) << lcu_sh;
    y_base      = PIX_W'(cur_y) << lcu_sh;
    pm_idx      = (6'(cur_y) << (2'd3 - size_q)) + 6'(cur_x);
    credit_used = {1'b0, fifo_count} + {2'b0, inflight};
    // A head leaving this cycle frees its slot for the read issued now.
    credit_lim  = 3'd2 + {2'b0, in_en};
    start_ok    = start && ((state == S_IDLE) || (state == S_DONE));
  end

  assign fm_addr  = {y_base + PIX_W'(row), x_base + PIX_W'(col)};
  assign fm_rd    = (state == S_STREAM) && (credit_used < credit_lim);
  assign pm_addr  = PARAM_AW'(pm_idx);
  assign pm_rd    = (state == S_PARAM);
  assign done     = (state == S_DONE);
  assign lcu_size = size_q;

  assign in_en = (fifo_count != 2'd0) && !busy;
  assign {din, sao_type, sao_band_pos, sao_eo_class, sao_offset, lcu_x, lcu_y} = mem[rd_ptr];

  // Frame sequencer: parameter fetch, pixel issue, LCU advance, drain.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      size_q  <= 2'd0;
      cur_x   <= 3'd0;
      cur_y   <= 3'd0;
      row     <= 6'd0;
      col     <= 6'd0;
      param_q <= 24'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            size_q <= (cfg_lcu_size == 2'd3) ? 2'd2 : cfg_lcu_size;
            cur_x  <= 3'd0;
            cur_y  <= 3'd0;
            state  <= S_PARAM;
          end
        end
        S_PARAM: state <= S_PWAIT;
        S_PWAIT: begin
          param_q <= pm_q;
          row     <= 6'd0;
          col     <= 6'd0;
          state   <= S_STREAM;
        end
        S_STREAM: begin
          if (fm_rd) begin
            if (col == n_m1) begin
              col <= 6'd0;
              if (row == n_m1) state <= S_NEXT;
              else             row   <= row + 6'd1;
            end else begin
              col <= col + 6'd1;
            end
          end
        end
        S_NEXT: begin
          // Wait for the last read so it is tagged with this LCU's position.
          if (!inflight) begin
            if (cur_x == lpr_m1) begin
              if (cur_y == lpr_m1) begin
                state <= S_DRAIN;
              end else begin
                cur_x <= 3'd0;
                cur_y <= cur_y + 3'd1;
                state <= S_PARAM;
              end
            end else begin
              cur_x <= cur_x + 3'd1;
              state <= S_PARAM;
            end
          end
        end
        S_DRAIN: if (fifo_count == 2'd0) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output FIFO: capture returning pixels tagged with the LCU context, pop on in_en.
  // NOTE: the two entries are reset so the head outputs read 0 straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
      inflight   <= 1'b0;
    end else begin
      inflight <= fm_rd;
      if (inflight) begin
        mem[wr_ptr] <= {fm_q, param_q, cur_x, cur_y};
        wr_ptr      <= ~wr_ptr;
      end
      if (in_en) rd_ptr <= ~rd_ptr;
      case ({inflight, in_en})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef SAO_FEED_STATS_EN
  // Statistics: stalled-head cycles (saturating) and completed LCUs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 16'd0;
      lcu_cnt   <= 7'd0;
    end else if (start_ok) begin
      stall_cnt <= 16'd0;
      lcu_cnt   <= 7'd0;
    end else begin
      if ((fifo_count != 2'd0) && busy && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if ((state == S_NEXT) && !inflight)
        lcu_cnt <= lcu_cnt + 7'd1;
    end
  end
`else
  // Without statistics the accepted-start decode has no consumer.
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_sao_lcu_feeder.sv
// Directed bench for sao_lcu_feeder: frame/param ROM models, a negedge
// monitor comparing every issued address and every delivered pixel against
// an LCU-raster reference, and a linear sequence of directed steps.
module tb_sao_lcu_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  cfg_lcu_size;
  logic [13:0] fm_addr;
  logic        fm_rd;
  logic [7:0]  fm_q;
  logic [5:0]  pm_addr;
  logic        pm_rd;
  logic [23:0] pm_q;
  logic        in_en;
  logic [7:0]  din;
  logic [1:0]  sao_type;
  logic [4:0]  sao_band_pos;
  logic        sao_eo_class;
  logic [15:0] sao_offset;
  logic [2:0]  lcu_x;
  logic [2:0]  lcu_y;
  logic [1:0]  lcu_size;
  logic        busy;
  logic        done;
`ifdef SAO_FEED_STATS_EN
  logic [15:0] stall_cnt;
  logic [6:0]  lcu_cnt;
`endif

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Event counters owned by the monitor; bases owned by the main sequence.
  int iss_cnt = 0;
  int out_cnt = 0;
  int pm_cnt  = 0;
  int iss_base = 0;
  int out_base = 0;
  int pm_base  = 0;
  int run_size = 0;

  always #5 clk = ~clk;

  sao_lcu_feeder #(.IMG_W(128), .PARAM_AW(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cfg_lcu_size (cfg_lcu_size),
    .fm_addr      (fm_addr),
    .fm_rd        (fm_rd),
    .fm_q         (fm_q),
    .pm_addr      (pm_addr),
    .pm_rd        (pm_rd),
    .pm_q         (pm_q),
    .in_en        (in_en),
    .din          (din),
    .sao_type     (sao_type),
    .sao_band_pos (sao_band_pos),
    .sao_eo_class (sao_eo_class),
    .sao_offset   (sao_offset),
    .lcu_x        (lcu_x),
    .lcu_y        (lcu_y),
    .lcu_size     (lcu_size),
    .busy         (busy),
    .done         (done)
`ifdef SAO_FEED_STATS_EN
    ,
    .stall_cnt    (stall_cnt),
    .lcu_cnt      (lcu_cnt)
`endif
  );

  // Frame ROM: pixel value is the low byte of its address, 1-cycle latency.
  always @(posedge clk) if (fm_rd) fm_q <= fm_addr[7:0];

  // Parameter ROM: entry k = 24'h400000 | k, 1-cycle latency.
  always @(posedge clk) if (pm_rd) pm_q <= 24'h400000 | 24'(pm_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: frame address of the idx-th pixel in LCU-raster order.
  function automatic int exp_addr(input int sz, input int idx);
    int n, lpr, lcu, off;
    n   = 16 << sz;
    lpr = 128 / n;
    lcu = idx / (n * n);
    off = idx % (n * n);
    return (((lcu / lpr) * n + off / n) * 128) + (lcu % lpr) * n + (off % n);
  endfunction

  function automatic int exp_lcu(input int sz, input int idx);
    int n;
    n = 16 << sz;
    return idx / (n * n);
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    int idx, a, k, lpr;
    if (fm_rd) begin
      check("fm_addr", 32'(fm_addr), 32'(exp_addr(run_size, iss_cnt - iss_base)));
      iss_cnt++;
    end
    if (pm_rd) pm_cnt++;
    if (busy) check("in_en_busy", 32'(in_en), 32'd0);
    if (in_en) begin
      idx = out_cnt - out_base;
      a   = exp_addr(run_size, idx);
      k   = exp_lcu(run_size, idx);
      lpr = 128 / (16 << run_size);
      check("din", 32'(din), 32'(a[7:0]));
      check("lcu_x", 32'(lcu_x), 32'(k % lpr));
      check("lcu_y", 32'(lcu_y), 32'(k / lpr));
      check("params", 32'({sao_type, sao_band_pos, sao_eo_class, sao_offset}),
            32'h0040_0000 | 32'(k));
      check("done_during_stream", 32'(done), 32'd0);
      check("outstanding_le_3", 32'((iss_cnt - iss_base - idx) <= 3), 32'd1);
      if (run_size == 0 && idx == 16)  check("px16_din", 32'(din), 32'h80);
      if (run_size == 0 && idx == 256) check("lcu10_first_din", 32'(din), 32'h10);
      if (run_size == 2 && lcu_x == 3'd1 && lcu_y == 3'd1) begin
        check("lcu11_type", 32'(sao_type), 32'd1);
        check("lcu11_offset", 32'(sao_offset), 32'h0003);
      end
      out_cnt++;
    end
  end

  task automatic do_start(input logic [1:0] cfg, input int eff_size);
    @(posedge clk);
    #1;
    run_size     = eff_size;
    iss_base     = iss_cnt;
    out_base     = out_cnt;
    pm_base      = pm_cnt;
    cfg_lcu_size = cfg;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Returns at a rising edge once target pixels have been delivered.
  task automatic wait_out(input int target, input int budget);
    int n;
    n = 0;
    while ((out_cnt - out_base) < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("wait_out_timeout", 32'((out_cnt - out_base) >= target), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic check_frame(input string tag, input int pm_reads);
    check({tag, "_pixels"}, 32'(out_cnt - out_base), 32'd16384);
    check({tag, "_issues"}, 32'(iss_cnt - iss_base), 32'd16384);
    check({tag, "_pm_reads"}, 32'(pm_cnt - pm_base), 32'(pm_reads));
  endtask

  initial begin
    int snap, n;
    reset        = 1'b1;
    start        = 1'b0;
    cfg_lcu_size = 2'd0;
    busy         = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_in_en", 32'(in_en), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fm_rd", 32'(fm_rd), 32'd0);
    check("rst_pm_rd", 32'(pm_rd), 32'd0);
    check("rst_fm_addr", 32'(fm_addr), 32'd0);
    check("rst_din", 32'(din), 32'd0);
    check("rst_lcu_size", 32'(lcu_size), 32'd0);
`ifdef SAO_FEED_STATS_EN
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_lcu_cnt", 32'(lcu_cnt), 32'd0);
`endif
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_done", 32'(done), 32'd0);

    // Size 0, busy low; a start mid-stream must be ignored.
    do_start(2'd0, 0);
    wait_out(300, 2000);
    #1;
    cfg_lcu_size = 2'd2;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("ignored_start_size", 32'(lcu_size), 32'd0);
`ifdef SAO_FEED_STATS_EN
    wait_out(1000, 4000);
    #1;
    busy = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    busy = 1'b0;
`endif
    wait_done(20000);
    check_frame("s0", 64);
    check("s0_lcu_size", 32'(lcu_size), 32'd0);
`ifdef SAO_FEED_STATS_EN
    check("s0_stall_cnt", 32'(stall_cnt), 32'd10);
    check("s0_lcu_cnt", 32'(lcu_cnt), 32'd64);
`endif

    // Illegal size 3 behaves as 64x64; restarted from DONE.
    do_start(2'd3, 2);
    @(negedge clk);
    check("s3_lcu_size", 32'(lcu_size), 32'd2);
    check("restart_done_low", 32'(done), 32'd0);
    wait_done(20000);
    check_frame("s2", 4);
`ifdef SAO_FEED_STATS_EN
    check("s2_stall_cnt", 32'(stall_cnt), 32'd0);
    check("s2_lcu_cnt", 32'(lcu_cnt), 32'd4);
`endif

    // Size 1 with a 5-cycle busy pulse at pixel 100 (addr 388 -> 0x84).
    do_start(2'd1, 1);
    wait_out(100, 2000);
    #1;
    snap = out_cnt;
    busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_en", 32'(in_en), 32'd0);
      check("stall_din_hold", 32'(din), 32'h84);
      @(posedge clk);
      #1;
    end
    busy = 1'b0;
    check("stall_no_pop", 32'(out_cnt - snap), 32'd0);
    wait_done(20000);
    check_frame("s1", 16);

    // Size 0, reset while streaming LCU(2,3).
    do_start(2'd0, 0);
    n = 0;
    while ((iss_cnt - iss_base) < 26 * 256 + 50 && n < 10000) begin
      @(posedge clk);
      n++;
    end
    check("reach_lcu23", 32'((iss_cnt - iss_base) >= 26 * 256 + 50), 32'd1);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_in_en", 32'(in_en), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_fm_rd", 32'(fm_rd), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("postrst_in_en", 32'(in_en), 32'd0);
    check("postrst_done", 32'(done), 32'd0);

    // Replay from LCU(0,0), size 0, random busy at ~30% duty.
    do_start(2'd0, 0);
    n = 0;
    while (!done && n < 40000) begin
      @(posedge clk);
      #1;
      busy = ($urandom_range(0, 99) < 30);
      n++;
    end
    busy = 1'b0;
    @(negedge clk);
    check("rand_done", 32'(done), 32'd1);
    check_frame("rand", 64);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
